// File: rtl/timer_array_if.sv
// Bus bundle for timer_array: per-channel control in, per-channel status out.
interface timer_array_if #(
    parameter int unsigned TIMER_NUM = 5,
    parameter int unsigned CNT_W     = 10,
    parameter int unsigned PRE_W     = 4
);
    logic [TIMER_NUM*CNT_W-1:0] load_value;
    logic [TIMER_NUM-1:0]       start;
    logic [TIMER_NUM-1:0]       stop;
    logic [TIMER_NUM-1:0]       mode;
    logic [PRE_W-1:0]           prescale;
    logic [TIMER_NUM-1:0]       time_out;
    logic [TIMER_NUM-1:0]       busy;
    logic [TIMER_NUM*CNT_W-1:0] count;

    modport master (
        output load_value, start, stop, mode, prescale,
        input  time_out, busy, count
    );

    modport slave (
        input  load_value, start, stop, mode, prescale,
        output time_out, busy, count
    );
endinterface

// File: rtl/timer_array.sv
// Bank of independent down-counting timers sharing one tick prescaler.
// Each channel counts load_value..0 on ticks, then pulses time_out for one
// cycle and either reloads (periodic) or returns to IDLE (one-shot).
module timer_array #(
    parameter int unsigned TIMER_NUM = 5,
    parameter int unsigned CNT_W     = 10,
    parameter int unsigned PRE_W     = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    timer_array_if.slave  bus
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    state_e               state_q [TIMER_NUM];
    state_e               state_d [TIMER_NUM];
    logic [CNT_W-1:0]     cnt_q   [TIMER_NUM];
    logic [CNT_W-1:0]     cnt_d   [TIMER_NUM];
    logic [CNT_W-1:0]     load_c  [TIMER_NUM];
    logic [TIMER_NUM-1:0] time_out_q;
    logic [TIMER_NUM-1:0] time_out_d;
    logic [PRE_W-1:0]     pre_cnt_q;
    logic [PRE_W-1:0]     pre_cnt_d;
    logic                 tick_c;
    logic [TIMER_NUM-1:0]       busy_c;
    logic [TIMER_NUM*CNT_W-1:0] count_c;

    // Prescaler: >= compare so lowering prescale below pre_cnt ticks next edge.
    always_comb begin
        tick_c    = (pre_cnt_q >= bus.prescale);
        pre_cnt_d = tick_c ? '0 : pre_cnt_q + PRE_W'(1);
    end

    // Prescaler register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_cnt_q <= '0;
        end else begin
            pre_cnt_q <= pre_cnt_d;
        end
    end

    // Unpack per-channel load values.
    always_comb begin
        for (int i = 0; i < int'(TIMER_NUM); i++) begin
            load_c[i] = bus.load_value[i*CNT_W +: CNT_W];
        end
    end

    // Per-channel next state: stop > start > tick.
    always_comb begin
        time_out_d = '0;
        for (int i = 0; i < int'(TIMER_NUM); i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
            if (bus.stop[i]) begin
                state_d[i] = IDLE;
                cnt_d[i]   = '0;
            end else if (bus.start[i]) begin
                state_d[i] = RUN;
                cnt_d[i]   = load_c[i];
            end else begin
                case (state_q[i])
                    RUN: begin
                        if (tick_c) begin
                            if (cnt_q[i] != '0) begin
                                cnt_d[i] = cnt_q[i] - CNT_W'(1);
                            end else begin
                                time_out_d[i] = 1'b1;
                                if (bus.mode[i]) begin
                                    cnt_d[i] = load_c[i];
                                end else begin
                                    state_d[i] = IDLE;
                                    cnt_d[i]   = '0;
                                end
                            end
                        end
                    end
                    default: begin
                        state_d[i] = IDLE;
                        cnt_d[i]   = '0;
                    end
                endcase
            end
        end
    end

    // Channel state, counter and expiry pulse registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(TIMER_NUM); i++) begin
                state_q[i] <= IDLE;
                cnt_q[i]   <= '0;
            end
            time_out_q <= '0;
        end else begin
            for (int i = 0; i < int'(TIMER_NUM); i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
            time_out_q <= time_out_d;
        end
    end

    // Pack flop contents onto the output bus.
    always_comb begin
        busy_c  = '0;
        count_c = '0;
        for (int i = 0; i < int'(TIMER_NUM); i++) begin
            busy_c[i]                   = (state_q[i] == RUN);
            count_c[i*CNT_W +: CNT_W]   = cnt_q[i];
        end
    end

    assign bus.time_out = time_out_q;
    assign bus.busy     = busy_c;
    assign bus.count    = count_c;

endmodule
